// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a registered one-hot grant and encoded id.
// Owner keeps the grant while requesting, up to MAX_HOLD cycles, then rotation is forced.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [3:0]        gnt_n;
  logic [1:0]        gnt_id_n;
  logic              preempt_n;

  logic [1:0] owner, after_owner, win_ptr, win_next;
  logic [3:0] others;
  logic       timeout;

  // First set bit of r, searching upward from start with wrap-around.
  function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign owner       = gnt_id;
  assign after_owner = gnt_id + 2'd1;
  assign others      = req & ~gnt;
  assign win_ptr     = pick(ptr, req);
  assign win_next    = pick(after_owner, others);
  assign timeout     = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    preempt_n = 1'b0;
    case (state)
      IDLE: begin
        if (en && (req != 4'd0)) begin
          state_n  = GRANT;
          gnt_n    = 4'b0001 << win_ptr;
          gnt_id_n = win_ptr;
          hold_n   = '0;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          ptr_n  = after_owner;
          hold_n = '0;
          if (en && (others != 4'd0)) begin
            gnt_n    = 4'b0001 << win_next;
            gnt_id_n = win_next;
          end else begin
            state_n  = IDLE;
            gnt_n    = 4'd0;
            gnt_id_n = 2'd0;
          end
        end else if (timeout) begin
          // Forced rotation; with no eligible rival the same owner is renewed.
          preempt_n = 1'b1;
          ptr_n     = after_owner;
          hold_n    = '0;
          if (en && (others != 4'd0)) begin
            gnt_n    = 4'b0001 << win_next;
            gnt_id_n = win_next;
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = 4'd0;
        gnt_id_n = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt       <= 4'd0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= (gnt_n != 4'd0);
      preempt   <= preempt_n;
    end
  end

endmodule
